// File: rtl/issue_select_scheduler.sv
// Oldest-first issue select for two ALU pipes (FU0/FU1) and one non-pipelined MUL unit (FU2).
// Define ISSUE_SCHED_STATS_EN to add the stat_issued / stat_mul_stall / stat_empty counters.

module issue_age_lane #(
   parameter int IQ_DEPTH = 16,
   parameter int IDX_W    = 4,
   parameter int LANE     = 0
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                alloc_valid,
   input  logic [IDX_W-1:0]    alloc_index,
   input  logic [IQ_DEPTH-1:0] alu_cand,
   input  logic [IQ_DEPTH-1:0] mul_cand,
   output logic [IQ_DEPTH-1:0] older,
   output logic                oldest_alu,
   output logic                oldest_mul
);
   // older[j] holds age[j][LANE]: entry j was allocated before this one
   always_ff @(posedge clk) begin
      if (clr)
         older <= '0;
      else if (alloc_valid) begin
         if (alloc_index == IDX_W'(LANE)) begin
            older       <= '1;
            older[LANE] <= 1'b0;
         end else
            older[alloc_index] <= 1'b0;
      end
   end

   assign oldest_alu = alu_cand[LANE] & ~|(older & alu_cand);
   assign oldest_mul = mul_cand[LANE] & ~|(older & mul_cand);
endmodule

module issue_select_scheduler #(
   parameter int IQ_DEPTH      = 16,
   parameter int IDX_W         = 4,
   parameter int MUL_OCCUPANCY = 4
`ifdef ISSUE_SCHED_STATS_EN
  ,parameter int STAT_W        = 32
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                alloc_valid,
   input  logic [IDX_W-1:0]    alloc_index,
   input  logic [IQ_DEPTH-1:0] entry_ready,
   input  logic [IQ_DEPTH-1:0] entry_is_mul,
   input  logic [2:0]          fu_stall,
   output logic                fu0_grant_valid,
   output logic [IDX_W-1:0]    fu0_grant_index,
   output logic                fu1_grant_valid,
   output logic [IDX_W-1:0]    fu1_grant_index,
   output logic                fu2_grant_valid,
   output logic [IDX_W-1:0]    fu2_grant_index,
   output logic [IQ_DEPTH-1:0] issue_clear,
   output logic                fu2_busy
`ifdef ISSUE_SCHED_STATS_EN
  ,output logic [STAT_W-1:0]   stat_issued
  ,output logic [STAT_W-1:0]   stat_mul_stall
  ,output logic [STAT_W-1:0]   stat_empty
`endif
);
   localparam int CNT_W = (MUL_OCCUPANCY > 1) ? $clog2(MUL_OCCUPANCY) : 1;

   typedef struct packed {
      logic             vld;
      logic [IDX_W-1:0] idx;
   } grant_t;

   if (IDX_W != $clog2(IQ_DEPTH)) begin : g_idx_w_check
      $error("issue_select_scheduler: IDX_W must equal $clog2(IQ_DEPTH)");
   end

   // Lowest index breaks ties; with a consistent age matrix there is one winner.
   function automatic grant_t pick(input logic [IQ_DEPTH-1:0] win);
      grant_t g;
      g = '0;
      for (int i = IQ_DEPTH-1; i >= 0; i--)
         if (win[i]) begin
            g.vld = 1'b1;
            g.idx = IDX_W'(i);
         end
      return g;
   endfunction

   function automatic logic [IQ_DEPTH-1:0] onehot(input grant_t g);
      logic [IQ_DEPTH-1:0] v;
      v = '0;
      if (g.vld) v[g.idx] = 1'b1;
      return v;
   endfunction

   logic                               clr;
   logic [IQ_DEPTH-1:0]                alu_cand, mul_cand, alu_win, mul_win;
   logic [IQ_DEPTH-1:0]                fu1_set, fu1_win;
   logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0]  older;
   logic [CNT_W-1:0]                   mul_cnt;
   grant_t                             g0, g1, g2;

   assign clr      = reset | flush;
   assign alu_cand = entry_ready & ~entry_is_mul;
   assign mul_cand = entry_ready &  entry_is_mul;

   for (genvar i = 0; i < IQ_DEPTH; i++) begin : g_lane
      issue_age_lane #(.IQ_DEPTH(IQ_DEPTH), .IDX_W(IDX_W), .LANE(i)) u_lane (
         .clk        (clk),
         .clr        (clr),
         .alloc_valid(alloc_valid),
         .alloc_index(alloc_index),
         .alu_cand   (alu_cand),
         .mul_cand   (mul_cand),
         .older      (older[i]),
         .oldest_alu (alu_win[i]),
         .oldest_mul (mul_win[i])
      );
   end

   always_comb begin
      g0 = '0;
      if (!clr && !fu_stall[0]) g0 = pick(alu_win);
   end

   // FU1 re-runs the oldest search with the FU0 winner removed
   always_comb begin
      fu1_win = '0;
      fu1_set = alu_cand & ~onehot(g0);
      for (int i = 0; i < IQ_DEPTH; i++)
         fu1_win[i] = fu1_set[i] & ~|(older[i] & fu1_set);
      g1 = '0;
      if (!clr && !fu_stall[1]) g1 = pick(fu1_win);
   end

   always_comb begin
      g2 = '0;
      if (!clr && !fu_stall[2] && !fu2_busy) g2 = pick(mul_win);
   end

   assign fu0_grant_valid = g0.vld;
   assign fu0_grant_index = g0.idx;
   assign fu1_grant_valid = g1.vld;
   assign fu1_grant_index = g1.idx;
   assign fu2_grant_valid = g2.vld;
   assign fu2_grant_index = g2.idx;
   assign issue_clear     = onehot(g0) | onehot(g1) | onehot(g2);
   assign fu2_busy        = (mul_cnt != '0);

   always_ff @(posedge clk) begin
      if (clr)
         mul_cnt <= '0;
      else if (g2.vld)
         mul_cnt <= CNT_W'(MUL_OCCUPANCY-1);
      else if (mul_cnt != '0)
         mul_cnt <= mul_cnt - 1'b1;
   end

`ifdef ISSUE_SCHED_STATS_EN
   // Statistics survive a flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_issued    <= '0;
         stat_mul_stall <= '0;
         stat_empty     <= '0;
      end else begin
         stat_issued <= stat_issued + STAT_W'(2'(g0.vld) + 2'(g1.vld) + 2'(g2.vld));
         if ((|mul_cand) && fu2_busy)
            stat_mul_stall <= stat_mul_stall + 1'b1;
         if (!(g0.vld || g1.vld || g2.vld))
            stat_empty <= stat_empty + 1'b1;
      end
   end
`endif
endmodule
